multicycle_control_fsm: RTL and testbench

//  Sequencing controller for the multicycle RV32I core, replacing the single-cycle control unit.

---
 rtl/multicycle_control_fsm.sv | 253 +++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: steps the shared datapath through fetch/decode/execute/mem/writeback.
// Moore outputs except mem_ready-qualified fetch strobes and branch pc_write; all outputs 0 while rst.
`ifndef OPCODE_LEN
`define OPCODE_LEN 7
`endif
`ifndef FUNCT3_LEN
`define FUNCT3_LEN 3
`endif
`ifndef ALU_CNTL_BITS_COUNT
`define ALU_CNTL_BITS_COUNT 4
`endif
`ifndef IMM_TYPE_BITS_COUNT
`define IMM_TYPE_BITS_COUNT 3
`endif
`ifndef BRANCH_TYPE_BITS_COUNT
`define BRANCH_TYPE_BITS_COUNT 3
`endif

module multicycle_control_fsm #(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [`OPCODE_LEN-1:0]               opcode,
   input  logic [`FUNCT3_LEN-1:0]               funct3,
   input  logic                                 funct7_bit5,
   input  logic                                 mem_ready,
   input  logic                                 branch_taken,
   output logic                                 mem_req,
   output logic                                 mem_we,
   output logic                                 adr_src,
   output logic                                 ir_write,
   output logic                                 pc_write,
   output logic                                 reg_write,
   output logic [1:0]                           alu_src_a,
   output logic [1:0]                           alu_src_b,
   output logic [`ALU_CNTL_BITS_COUNT-1:0]      alu_control,
   output logic [`IMM_TYPE_BITS_COUNT-1:0]      imm_type,
   output logic [1:0]                           result_src,
   output logic [`BRANCH_TYPE_BITS_COUNT-1:0]   branch_type,
   output logic                                 instr_retired,
   output logic                                 illegal_instr,
   output logic                                 bus_error
);
   localparam logic [`OPCODE_LEN-1:0] OPC_LOAD   = `OPCODE_LEN'(7'b0000011);
   localparam logic [`OPCODE_LEN-1:0] OPC_STORE  = `OPCODE_LEN'(7'b0100011);
   localparam logic [`OPCODE_LEN-1:0] OPC_OP     = `OPCODE_LEN'(7'b0110011);
   localparam logic [`OPCODE_LEN-1:0] OPC_OPIMM  = `OPCODE_LEN'(7'b0010011);
   localparam logic [`OPCODE_LEN-1:0] OPC_BRANCH = `OPCODE_LEN'(7'b1100011);
   localparam logic [`OPCODE_LEN-1:0] OPC_JAL    = `OPCODE_LEN'(7'b1101111);
   localparam logic [`OPCODE_LEN-1:0] OPC_JALR   = `OPCODE_LEN'(7'b1100111);
   localparam logic [`OPCODE_LEN-1:0] OPC_LUI    = `OPCODE_LEN'(7'b0110111);
   localparam logic [`OPCODE_LEN-1:0] OPC_AUIPC  = `OPCODE_LEN'(7'b0010111);

   localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [CW-1:0] WAIT_LIM = CW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
      S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_WB, S_LUI, S_TRAP
   } state_t;

   typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT} alu_op_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          illegal_q, illegal_d;
   logic          bus_err_q, bus_err_d;

   logic    mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c, retired_c;
   logic [1:0] src_a_c, src_b_c, result_c;
   alu_op_t alu_op;
   logic [`ALU_CNTL_BITS_COUNT-1:0]    alu_ctl_c;
   logic [`IMM_TYPE_BITS_COUNT-1:0]    imm_c;

   always_comb begin
      state_d     = state_q;
      illegal_d   = illegal_q;
      bus_err_d   = bus_err_q;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      adr_src_c   = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      retired_c   = 1'b0;
      src_a_c     = 2'd0;
      src_b_c     = 2'd0;
      result_c    = 2'd0;
      alu_op      = ALU_OP_ADD;
      unique case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            src_b_c   = 2'd2;
            result_c  = 2'd2;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            src_a_c = 2'd1;
            src_b_c = 2'd1;
            if (opcode == OPC_LOAD || opcode == OPC_STORE) state_d = S_MEM_ADR;
            else if (opcode == OPC_OP)     state_d = S_EXEC_R;
            else if (opcode == OPC_OPIMM)  state_d = S_EXEC_I;
            else if (opcode == OPC_BRANCH) state_d = S_BRANCH;
            else if (opcode == OPC_JAL)    state_d = S_JAL;
            else if (opcode == OPC_JALR)   state_d = S_JALR;
            else if (opcode == OPC_LUI)    state_d = S_LUI;
            else if (opcode == OPC_AUIPC)  state_d = S_ALU_WB;
            else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_MEM_ADR: begin
            src_a_c = 2'd2;
            src_b_c = 2'd1;
            state_d = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req_c = 1'b1;
            adr_src_c = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_c = 1'b1;
            result_c    = 2'd1;
            retired_c   = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            adr_src_c = 1'b1;
            if (mem_ready) begin
               retired_c = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_EXEC_R, S_EXEC_I: begin
            src_a_c = 2'd2;
            src_b_c = (state_q == S_EXEC_I) ? 2'd1 : 2'd0;
            alu_op  = ALU_OP_FUNCT;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_c = 1'b1;
            retired_c   = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            src_a_c    = 2'd2;
            alu_op     = ALU_OP_SUB;
            pc_write_c = branch_taken;
            retired_c  = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL, S_JALR_WB: begin
            // Link value old_pc+4 goes to the GPR; the datapath takes the new PC from the ALU result register.
            src_a_c     = 2'd1;
            src_b_c     = 2'd2;
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            result_c    = 2'd2;
            retired_c   = 1'b1;
            state_d     = S_FETCH;
         end
         S_JALR: begin
            src_a_c = 2'd2;
            src_b_c = 2'd1;
            state_d = S_JALR_WB;
         end
         S_LUI: begin
            src_a_c     = 2'd3;
            src_b_c     = 2'd1;
            reg_write_c = 1'b1;
            result_c    = 2'd2;
            retired_c   = 1'b1;
            state_d     = S_FETCH;
         end
         default: state_d = S_TRAP;
      endcase

      // A ready arriving on the limit cycle has already moved the state on, so it wins.
      if (MEM_WAIT_MAX != 0 && mem_req_c && !mem_ready && wait_cnt_q == WAIT_LIM) begin
         state_d   = S_TRAP;
         bus_err_d = 1'b1;
      end
      wait_cnt_d = (mem_req_c && !mem_ready && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
   end

   always_comb begin
      alu_ctl_c = `ALU_CNTL_BITS_COUNT'(0);
      if (alu_op == ALU_OP_SUB) begin
         alu_ctl_c = `ALU_CNTL_BITS_COUNT'(1);
      end else if (alu_op == ALU_OP_FUNCT) begin
         unique case (funct3)
            3'b000:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'((opcode == OPC_OP && funct7_bit5) ? 1 : 0);
            3'b001:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(7);
            3'b010:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(5);
            3'b011:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(6);
            3'b100:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(4);
            3'b101:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(funct7_bit5 ? 9 : 8);
            3'b110:  alu_ctl_c = `ALU_CNTL_BITS_COUNT'(3);
            default: alu_ctl_c = `ALU_CNTL_BITS_COUNT'(2);
         endcase
      end
   end

   always_comb begin
      imm_c = `IMM_TYPE_BITS_COUNT'(0);
      if (opcode == OPC_STORE)                         imm_c = `IMM_TYPE_BITS_COUNT'(1);
      else if (opcode == OPC_BRANCH)                   imm_c = `IMM_TYPE_BITS_COUNT'(2);
      else if (opcode == OPC_LUI || opcode == OPC_AUIPC) imm_c = `IMM_TYPE_BITS_COUNT'(3);
      else if (opcode == OPC_JAL)                      imm_c = `IMM_TYPE_BITS_COUNT'(4);
   end

   // Gating on rst directly makes mem_req/mem_we fall the moment reset rises, mid-access included.
   always_comb begin
      mem_req       = !rst && mem_req_c;
      mem_we        = !rst && mem_we_c;
      adr_src       = !rst && adr_src_c;
      ir_write      = !rst && ir_write_c;
      pc_write      = !rst && pc_write_c;
      reg_write     = !rst && reg_write_c;
      instr_retired = !rst && retired_c;
      illegal_instr = !rst && illegal_q;
      bus_error     = !rst && bus_err_q;
      alu_src_a     = rst ? 2'd0 : src_a_c;
      alu_src_b     = rst ? 2'd0 : src_b_c;
      result_src    = rst ? 2'd0 : result_c;
      alu_control   = rst ? '0 : alu_ctl_c;
      imm_type      = rst ? '0 : imm_c;
      branch_type   = (rst || state_q != S_BRANCH) ? '0 : `BRANCH_TYPE_BITS_COUNT'(funct3);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle strobe vectors checked against hand-computed tables.
// Strobe vector bit order: {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_retired}.
module tb_multicycle_control_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_bit5 = 1'b0;
   logic       mem_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [3:0] alu_control;
   logic [2:0] imm_type, branch_type;
   logic       instr_retired, illegal_instr, bus_error;

   int checks = 0;
   int failures = 0;

   multicycle_control_fsm #(.MEM_WAIT_MAX(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_bit5(funct7_bit5),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_type(imm_type), .result_src(result_src), .branch_type(branch_type),
      .instr_retired(instr_retired), .illegal_instr(illegal_instr), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   wire [6:0]  strb    = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, instr_retired};
   wire [24:0] all_out = {strb, alu_src_a, alu_src_b, alu_control, imm_type, result_src,
                          branch_type, illegal_instr, bus_error};

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = 7'b0010011;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (all_out !== 25'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", all_out, 25'd0);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   // ADDI x1,x0,5: FETCH, DECODE, EXEC_I, ALU_WB
   task automatic test_addi;
      logic [6:0] exp [4];
      exp = '{7'b1001100, 7'b0000000, 7'b0000000, 7'b0000011};
      opcode = 7'b0010011; funct3 = 3'b000; funct7_bit5 = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL addi_cyc%0d strb got=%b exp=%b", i, strb, exp[i]);
         end
         if (i == 2) begin
            checks++;
            if ({alu_src_a, alu_src_b, alu_control} !== {2'd2, 2'd1, 4'd0}) begin
               failures++;
               $display("FAIL addi_exec_alu got=%b exp=%b", {alu_src_a, alu_src_b, alu_control}, 8'b10010000);
            end
         end
         next_cycle();
      end
   endtask

   // LW with ready withheld for 3 cycles in MEM_RD
   task automatic test_lw_wait;
      logic [6:0] exp [8];
      logic       rdy [8];
      exp = '{7'b1001100, 7'b0, 7'b0, 7'b1010000, 7'b1010000, 7'b1010000, 7'b1010000, 7'b0000011};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 7'b0000011; funct3 = 3'b010;
      for (int i = 0; i < 8; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL lw_cyc%0d strb got=%b exp=%b", i, strb, exp[i]);
         end
         if (i == 7) begin
            checks++;
            if (result_src !== 2'd1) begin
               failures++;
               $display("FAIL lw_wb_result_src got=%0d exp=1", result_src);
            end
         end
         next_cycle();
      end
   endtask

   // SW with zero wait states, retiring in MEM_WR; the next test starts straight in FETCH
   task automatic test_store;
      logic [6:0] exp [4];
      exp = '{7'b1001100, 7'b0, 7'b0, 7'b1110001};
      opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL sw_cyc%0d strb got=%b exp=%b", i, strb, exp[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_branch(input logic taken);
      logic [6:0] exp [3];
      exp = '{7'b1001100, 7'b0, taken ? 7'b0000101 : 7'b0000001};
      opcode = 7'b1100011; funct3 = 3'b001; branch_taken = taken; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL branch_t%0d_cyc%0d strb got=%b exp=%b", taken, i, strb, exp[i]);
         end
         if (i == 2) begin
            checks++;
            if ({branch_type, alu_control} !== {3'b001, 4'd1}) begin
               failures++;
               $display("FAIL branch_type_alu got=%b exp=%b", {branch_type, alu_control}, 7'b0010001);
            end
         end
         next_cycle();
      end
      branch_taken = 1'b0;
   endtask

   task automatic test_lui;
      logic [6:0] exp [3];
      exp = '{7'b1001100, 7'b0, 7'b0000011};
      opcode = 7'b0110111; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL lui_cyc%0d strb got=%b exp=%b", i, strb, exp[i]);
         end
         if (i == 2) begin
            checks++;
            if ({alu_src_a, result_src} !== {2'd3, 2'd2}) begin
               failures++;
               $display("FAIL lui_srcs got=%b exp=%b", {alu_src_a, result_src}, 4'b1110);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_illegal;
      opcode = 7'b0000000; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (strb !== ((i == 0) ? 7'b1001100 : 7'b0000000)) begin
            failures++;
            $display("FAIL illegal_cyc%0d strb got=%b exp=%b", i, strb, (i == 0) ? 7'b1001100 : 7'b0);
         end
         checks++;
         if (illegal_instr !== (i >= 2)) begin
            failures++;
            $display("FAIL illegal_flag_cyc%0d got=%b exp=%b", i, illegal_instr, (i >= 2));
         end
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (illegal_instr !== 1'b0) begin
         failures++;
         $display("FAIL illegal_cleared got=%b exp=0", illegal_instr);
      end
      @(posedge clk);
      #1;
      // The state went FETCH -> DECODE already; finish that instruction as a LUI is not possible, so reset again.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      test_addi();
   endtask

   task automatic test_timeout;
      logic [6:0] exp [6];
      logic       rdy [6];
      opcode = 7'b0110111; mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem_ready = (i == 5);
         @(negedge clk);
         checks++;
         if ({strb, bus_error} !== ((i < 4) ? 8'b10000000 : 8'b00000001)) begin
            failures++;
            $display("FAIL timeout_cyc%0d strb_berr got=%b exp=%b", i, {strb, bus_error},
                     (i < 4) ? 8'b10000000 : 8'b00000001);
         end
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      exp = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1001100, 7'b0, 7'b0000011};
      rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if ({strb, bus_error} !== {exp[i], 1'b0}) begin
            failures++;
            $display("FAIL ready_at_limit_cyc%0d strb_berr got=%b exp=%b", i, {strb, bus_error}, {exp[i], 1'b0});
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_write;
      logic [6:0] exp [5];
      logic       rdy [5];
      exp = '{7'b1001100, 7'b0, 7'b0, 7'b1110000, 7'b1110000};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      opcode = 7'b0100011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         @(negedge clk);
         checks++;
         if (strb !== exp[i]) begin
            failures++;
            $display("FAIL sw_wait_cyc%0d strb got=%b exp=%b", i, strb, exp[i]);
         end
         next_cycle();
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_req, mem_we} !== 2'b00) begin
         failures++;
         $display("FAIL rst_drops_write got=%b exp=00", {mem_req, mem_we});
      end
      next_cycle();
      rst = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({strb, adr_src} !== {7'b1001100, 1'b0}) begin
         failures++;
         $display("FAIL first_access_after_rst got=%b exp=%b", {strb, adr_src}, 8'b10011000);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_lw_wait();
      test_store();
      test_branch(1'b1);
      test_branch(1'b0);
      test_lui();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
